// File: rtl/r30_entropy_stream.sv
// r30_entropy_stream
// Elementary cellular-automaton entropy source. An N-cell periodic ring is
// stepped under a programmable 8-bit Wolfram rule (Rule 30 after reset).
// After a seed is loaded, WARMUP steps are discarded. The ring then samples
// cell TAP once per step, packs W samples into a word, and offers that word
// on a valid/ready stream.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   seed_valid seed offer
//   seed_ready seed acceptance (low only while a word is pending)
//   seed       initial cell state (all-zero is replaced by a centre one-hot)
//   rule       rule table, captured only when a seed is accepted
//   out_valid  a word is available
//   out_ready  consumer accepts the word
//   out_data   entropy word; the first sampled bit lands in the MSB
module r30_entropy_stream #(
  parameter int          N            = 128,
  parameter int          W            = 32,
  parameter int          TAP          = N / 2,
  parameter int          WARMUP       = 64,
  parameter logic [7:0]  RULE_DEFAULT = 8'd30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_valid,
  output logic         seed_ready,
  input  logic [N-1:0] seed,
  input  logic [7:0]   rule,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int WCW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam int BCW = $clog2(W + 1);
  localparam logic [WCW-1:0] WARM_LAST = (WARMUP == 0) ? '0 : WCW'(WARMUP - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(W - 1);
  // An all-zero ring is a fixed point for many rules, so a zero seed is
  // replaced by a single live cell in the middle of the ring.
  localparam logic [N-1:0] CENTER_ONE_HOT = {{(N-1){1'b0}}, 1'b1} << (N / 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    FILL = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t         state_r;
  logic [N-1:0]   cells_r;
  logic [7:0]     rule_r;
  logic [W-1:0]   sr_r;
  logic [WCW-1:0] warm_cnt_r;
  logic [BCW-1:0] bit_cnt_r;

  logic [N-1:0]   cells_step_s;
  logic [N-1:0]   seed_load_s;
  logic [W:0]     sr_shift_s;
  logic           seed_accept_s;

  // Next ring state: each cell looks up the rule with its {left, self, right}
  // neighbourhood, wrapping at both ends of the ring.
  for (genvar i = 0; i < N; i++) begin : g_cell
    localparam int LEFT  = (i + 1) % N;
    localparam int RIGHT = (i + N - 1) % N;
    assign cells_step_s[i] = rule_r[{cells_r[LEFT], cells_r[i], cells_r[RIGHT]}];
  end

  assign seed_load_s   = (seed == '0) ? CENTER_ONE_HOT : seed;
  // The extra top bit simply falls off, which also covers W == 1.
  assign sr_shift_s    = {sr_r, cells_r[TAP]};
  assign seed_accept_s = seed_valid && seed_ready;
  assign out_data      = sr_r;

  // Control FSM together with the ring, shift register and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cells_r    <= '0;
      rule_r     <= RULE_DEFAULT;
      sr_r       <= '0;
      warm_cnt_r <= '0;
      bit_cnt_r  <= '0;
      out_valid  <= 1'b0;
      seed_ready <= 1'b1;
    end else if (seed_accept_s) begin
      // A seed restarts everything. Any partial warm-up or partial word is
      // dropped. A pending word cannot be dropped here, because seed_ready
      // is low in EMIT.
      cells_r    <= seed_load_s;
      rule_r     <= rule;
      sr_r       <= '0;
      warm_cnt_r <= '0;
      bit_cnt_r  <= '0;
      out_valid  <= 1'b0;
      seed_ready <= 1'b1;
      state_r    <= (WARMUP == 0) ? FILL : WARM;
    end else begin
      case (state_r)
        IDLE: begin
          seed_ready <= 1'b1;
        end
        WARM: begin
          cells_r <= cells_step_s;
          if (warm_cnt_r == WARM_LAST) begin
            warm_cnt_r <= '0;
            state_r    <= FILL;
          end else begin
            warm_cnt_r <= warm_cnt_r + WCW'(1);
          end
        end
        FILL: begin
          // Sample the cells before this cycle's step.
          sr_r    <= sr_shift_s[W-1:0];
          cells_r <= cells_step_s;
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_r  <= '0;
            state_r    <= EMIT;
            out_valid  <= 1'b1;
            seed_ready <= 1'b0;
          end else begin
            bit_cnt_r <= bit_cnt_r + BCW'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_r    <= FILL;
            out_valid  <= 1'b0;
            seed_ready <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          out_valid  <= 1'b0;
          seed_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
